ascon_sbox_layer_serial: RTL and testbench
==========================================

Name: ascon_sbox_layer_serial

Overview:
Sequential Ascon substitution layer (p_S). Accepts the full 320-bit permutation state as five 64-bit words x0..x4. Applies the 5-bit Ascon S-box to every bit column, LANES columns per clock, and returns the substituted state to the downstream linear-diffusion stage (p_L). Sits between the round-constant addition (p_C) and p_L in the round datapath, using replicated combinational S-box cores.

Parameters:
LANES, 4, columns substituted per cycle; legal values 1,2,4,8,16,32,64; any other value is a compile-time error.
NCYC, 64/LANES (derived localparam), cycles per layer pass.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  upstream state valid
in_ready  out  1  block can accept a state this cycle
x0_in..x4_in  in  64 each  input state words; bit j of word i is column j, row i
out_valid  out  1  substituted state valid
out_ready  in  1  downstream accepts state
x0_out..x4_out  out  64 each  substituted state words
busy  out  1  high while a pass is in progress

Behaviour:
- Single clock clk. Reset is synchronous and active-low on rst_n, sampled on the rising edge of clk. No asynchronous paths.
- Reset values: in_ready=0 during reset and 1 on the first cycle after release. out_valid=0, busy=0, x*_out=0, column counter=0, state FSM=IDLE.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, load the 320-bit shift register and go to RUN with cnt=0.
  - RUN: each cycle, substitute the LANES least-significant columns. Shift each word right by LANES and insert the results into the top LANES bit positions. Increment cnt. When cnt==NCYC-1, go to DONE.
  - DONE: out_valid=1 and x*_out driven from the register. On out_valid&out_ready, handle per the simultaneous-event rule below; otherwise hold all outputs stable.
- Simultaneous accept: in_ready = (state==IDLE) | (state==DONE & out_ready).
  - If the output fires and in_valid=1 in the same cycle, load the new state and go directly to RUN.
  - If the output fires with in_valid=0, go to IDLE.
- Latency: state accepted at edge T gives out_valid high after edge T+NCYC. Sustained throughput is one state per NCYC+1 cycles. For LANES=64 there is one RUN cycle.
- S-box convention: column value v = {x0[j],x1[j],x2[j],x3[j],x4[j]}, with x0 as MSB. Output follows the standard Ascon table:
  04 0b 1f 14 1a 15 09 02 1b 05 08 12 1d 03 06 1c 1e 13 07 0e 00 0d 11 18 10 0c 01 19 16 0a 0f 17 (indices 0..31).
- Column order: the final register holds column j in bit j. The shift-right arrangement guarantees this after exactly NCYC shifts.
- Counter width: max(1, $clog2(NCYC)). cnt does not wrap mid-pass; it resets to 0 on every load.
- busy = (state==RUN).
- in_valid is ignored outside the in_ready condition. Inputs are not required to hold after acceptance.
- Reset mid-RUN or mid-DONE: the pass is abandoned, all state returns to reset values, and no partial output is presented.
- x*_out may hold any value while out_valid=0. The implementation drives the shift register directly.

Decomposition:
- Shared package ascon_pkg:
  - ASCON_W=64, ASCON_ROWS=5
  - 5-bit column typedef
  - 320-bit state typedef (five 64-bit words)
  - FSM state enum {IDLE, RUN, DONE}
  - SBOX lookup constant, used as the verification reference
- Sub-module ascon_sbox5_lut: purely combinational 5-in/5-out Ascon S-box core. Instantiate it LANES times via generate.
- All sequencing (shift register, cnt, FSM) lives in the top module.

Test Plan:
1. Reset release, LANES=4: state all zero, in_valid pulse → after 16 cycles out_valid=1; x2_out=FFFF_FFFF_FFFF_FFFF, x0/x1/x3/x4_out=0.
2. All-ones state (every word FFFF_FFFF_FFFF_FFFF) → x0,x2,x3,x4_out all ones and x1_out=0 (column 0x1F → 0x17).
3. Column ramp, column j = j mod 32 → each output column j equals SBOX[j mod 32]. Run the same vector with LANES=1 (64-cycle latency) and LANES=64 (1-cycle latency).
4. Backpressure: hold out_ready=0 for 10 cycles in DONE → out_valid stays 1, outputs stable, in_ready=0. Raise out_ready with in_valid=1 and a new state → output fires, new state loaded the same cycle, next out_valid at +NCYC+1 cycles.
5. Reset mid-RUN: assert rst_n=0 at cnt=7 for one cycle → next cycle out_valid=0, busy=0, in_ready=1. A fresh state then completes correctly.
6. Random regression: 1000 random states with random valid/ready gaps, compared against the ascon_pkg SBOX model → zero mismatches, no dropped or duplicated transfers.

Source files
------------

// File: rtl/ascon_pkg.sv
// Shared Ascon types and constants for the serial substitution layer.
package ascon_pkg;

  localparam int unsigned ASCON_W    = 64;
  localparam int unsigned ASCON_ROWS = 5;

  typedef logic [ASCON_ROWS-1:0] ascon_col_t;
  typedef logic [ASCON_ROWS-1:0][ASCON_W-1:0] ascon_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_state_t;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  function automatic ascon_col_t sbox_lookup(input ascon_col_t v);
    return SBOX[v];
  endfunction

endpackage

// File: rtl/ascon_sbox5_lut.sv
// Combinational 5-bit Ascon S-box core; column bit 4 is row x0.
module ascon_sbox5_lut
  import ascon_pkg::*;
(
  input  ascon_col_t col_in,
  output ascon_col_t col_out
);

  logic a0, a1, a2, a3, a4;
  logic b0, b1, b2, b3, b4;

  // Bitsliced form of the Ascon table (chi-like core with linear pre/post mixing).
  always_comb begin
    a0 = col_in[4] ^ col_in[0];
    a4 = col_in[0] ^ col_in[1];
    a2 = col_in[2] ^ col_in[3];
    a1 = col_in[3];
    a3 = col_in[1];

    b0 = a0 ^ (~a1 & a2);
    b1 = a1 ^ (~a2 & a3);
    b2 = a2 ^ (~a3 & a4);
    b3 = a3 ^ (~a4 & a0);
    b4 = a4 ^ (~a0 & a1);

    col_out[3] = b1 ^ b0;
    col_out[4] = b0 ^ b4;
    col_out[1] = b3 ^ b2;
    col_out[2] = ~b2;
    col_out[0] = b4;
  end

endmodule

// File: rtl/ascon_sbox_layer_serial.sv
// Serial Ascon p_S layer: LANES columns per cycle through a 320-bit right-shifting register.
module ascon_sbox_layer_serial
  import ascon_pkg::*;
#(
  parameter int unsigned LANES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] x0_in,
  input  logic [63:0] x1_in,
  input  logic [63:0] x2_in,
  input  logic [63:0] x3_in,
  input  logic [63:0] x4_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] x0_out,
  output logic [63:0] x1_out,
  output logic [63:0] x2_out,
  output logic [63:0] x3_out,
  output logic [63:0] x4_out,
  output logic        busy
);

  localparam int unsigned NCYC  = ASCON_W / LANES;
  localparam int unsigned CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam bit LANES_OK = (LANES == 1) || (LANES == 2) || (LANES == 4) || (LANES == 8) ||
                            (LANES == 16) || (LANES == 32) || (LANES == 64);

  generate
    if (!LANES_OK) begin : g_bad_lanes
      $error("ascon_sbox_layer_serial: LANES must be a power of two between 1 and 64");
    end
  endgenerate

  fsm_state_t       state;
  logic [CNT_W-1:0] cnt;
  ascon_state_t     sr;
  ascon_state_t     sr_load;
  ascon_state_t     sr_shift;
  ascon_col_t       col_in  [LANES];
  ascon_col_t       col_out [LANES];
  logic [LANES-1:0] res     [ASCON_ROWS];
  logic             load;

  assign sr_load = {x4_in, x3_in, x2_in, x1_in, x0_in};

  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      col_in[l] = '0;
      for (int unsigned r = 0; r < ASCON_ROWS; r++) begin
        col_in[l][ASCON_ROWS-1-r] = sr[r][l];
      end
    end
  end

  generate
    for (genvar g = 0; g < LANES; g++) begin : g_lane
      ascon_sbox5_lut u_sbox (
        .col_in  (col_in[g]),
        .col_out (col_out[g])
      );
    end
  endgenerate

  // Results enter at the top; after NCYC shifts column j lands back in bit j.
  always_comb begin
    for (int unsigned r = 0; r < ASCON_ROWS; r++) begin
      res[r] = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
        res[r][l] = col_out[l][ASCON_ROWS-1-r];
      end
      sr_shift[r] = (sr[r] >> LANES) | (ASCON_W'(res[r]) << (ASCON_W - LANES));
    end
  end

  assign in_ready  = rst_n & ((state == IDLE) | ((state == DONE) & out_ready));
  assign load      = in_valid & in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);

  assign x0_out = sr[0];
  assign x1_out = sr[1];
  assign x2_out = sr[2];
  assign x3_out = sr[3];
  assign x4_out = sr[4];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      sr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            sr    <= sr_load;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sr  <= sr_shift;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(NCYC - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            if (in_valid) begin
              sr    <= sr_load;
              cnt   <= '0;
              state <= RUN;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_sbox_layer_serial.sv
// Self-checking bench for ascon_sbox_layer_serial against a table-driven column model.
module tb_ascon_sbox_layer_serial;

  localparam int unsigned NCYC = 16;

  localparam logic [4:0] TBL [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [319:0] st_in, st_out;
  logic [63:0]  o0, o1, o2, o3, o4;
  assign st_out = {o4, o3, o2, o1, o0};

  logic         a_iv, a_ir, a_ov, a_or, a_busy;
  logic         b_iv, b_ir, b_ov, b_or, b_busy;
  logic [63:0]  a0, a1, a2, a3, a4, b0, b1, b2, b3, b4;

  ascon_sbox_layer_serial #(.LANES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x0_in(st_in[63:0]), .x1_in(st_in[127:64]), .x2_in(st_in[191:128]),
    .x3_in(st_in[255:192]), .x4_in(st_in[319:256]),
    .out_valid(out_valid), .out_ready(out_ready),
    .x0_out(o0), .x1_out(o1), .x2_out(o2), .x3_out(o3), .x4_out(o4), .busy(busy)
  );

  ascon_sbox_layer_serial #(.LANES(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir),
    .x0_in(st_in[63:0]), .x1_in(st_in[127:64]), .x2_in(st_in[191:128]),
    .x3_in(st_in[255:192]), .x4_in(st_in[319:256]),
    .out_valid(a_ov), .out_ready(a_or),
    .x0_out(a0), .x1_out(a1), .x2_out(a2), .x3_out(a3), .x4_out(a4), .busy(a_busy)
  );

  ascon_sbox_layer_serial #(.LANES(64)) dut_l64 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir),
    .x0_in(st_in[63:0]), .x1_in(st_in[127:64]), .x2_in(st_in[191:128]),
    .x3_in(st_in[255:192]), .x4_in(st_in[319:256]),
    .out_valid(b_ov), .out_ready(b_or),
    .x0_out(b0), .x1_out(b1), .x2_out(b2), .x3_out(b3), .x4_out(b4), .busy(b_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Column j of the result is TBL applied to {x0[j],...,x4[j]}.
  function automatic logic [319:0] model(input logic [319:0] s);
    logic [319:0] r;
    logic [4:0]   v;
    r = '0;
    for (int j = 0; j < 64; j++) begin
      for (int i = 0; i < 5; i++) v[4-i] = s[64*i + j];
      v = TBL[v];
      for (int i = 0; i < 5; i++) r[64*i + j] = v[4-i];
    end
    return r;
  endfunction

  function automatic logic [319:0] rand_state();
    logic [319:0] s;
    for (int k = 0; k < 10; k++) s[32*k +: 32] = $urandom;
    return s;
  endfunction

  function automatic logic [319:0] ramp_state();
    logic [319:0] s;
    int unsigned  v;
    for (int j = 0; j < 64; j++) begin
      v = j % 32;
      for (int i = 0; i < 5; i++) s[64*i + j] = v[4-i];
    end
    return s;
  endfunction

  task automatic send(input logic [319:0] s, output int unsigned t_acc);
    int n;
    n = 0;
    st_in = s;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check("send_timeout", in_ready, 1'b1);
    @(posedge clk); #1;
    t_acc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic recv(output logic [319:0] s, output int unsigned t_ov, input bit fire);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!out_valid) check("recv_timeout", out_valid, 1'b1);
    t_ov = cyc;
    s = st_out;
    if (fire) out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [319:0] s, a, b, exp_a;
    int unsigned  t_acc, t_ov, ta, tb;
    bit           ga, gb;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; st_in = '0;
    a_iv = 1'b0; a_or = 1'b0; b_iv = 1'b0; b_or = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready_low", in_ready, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_out_zero", st_out, '0);
    @(posedge clk); #1;

    // All-zero state.
    send('0, t_acc);
    recv(s, t_ov, 1'b1);
    check("zero_latency", t_ov - t_acc, NCYC);
    check("zero_x2_ones", s[191:128], 64'hFFFF_FFFF_FFFF_FFFF);
    check("zero_data", s, model('0));

    // All-ones state: column 0x1F -> 0x17.
    send('1, t_acc);
    recv(s, t_ov, 1'b1);
    check("ones_const", s, {{64{1'b1}}, {64{1'b1}}, {64{1'b1}}, 64'h0, {64{1'b1}}});
    check("ones_data", s, model('1));

    // Ramp on the 4-lane instance.
    send(ramp_state(), t_acc);
    recv(s, t_ov, 1'b1);
    check("ramp_latency", t_ov - t_acc, NCYC);
    check("ramp_data", s, model(ramp_state()));

    // Ramp on the 1-lane and 64-lane instances together.
    st_in = ramp_state();
    a_iv = 1'b1; b_iv = 1'b1;
    @(negedge clk);
    check("l1_in_ready", a_ir, 1'b1);
    check("l64_in_ready", b_ir, 1'b1);
    @(posedge clk); #1;
    t_acc = cyc;
    a_iv = 1'b0; b_iv = 1'b0;
    check("l1_busy", a_busy, 1'b1);
    check("l64_busy", b_busy, 1'b1);
    ga = 1'b0; gb = 1'b0; ta = 0; tb = 0; a = '0; b = '0;
    for (int n = 0; n < 100 && !(ga && gb); n++) begin
      @(negedge clk);
      if (a_ov && !ga) begin ga = 1'b1; ta = cyc; a = {a4, a3, a2, a1, a0}; end
      if (b_ov && !gb) begin gb = 1'b1; tb = cyc; b = {b4, b3, b2, b1, b0}; end
    end
    check("l1_latency", ta - t_acc, 64);
    check("l64_latency", tb - t_acc, 1);
    check("l1_data", a, model(ramp_state()));
    check("l64_data", b, model(ramp_state()));
    @(posedge clk); #1;
    a_or = 1'b1; b_or = 1'b1;
    @(posedge clk); #1;
    a_or = 1'b0; b_or = 1'b0;

    // Backpressure in DONE, then simultaneous drain and reload.
    a = rand_state();
    b = rand_state();
    exp_a = model(a);
    send(a, t_acc);
    recv(s, t_ov, 1'b0);
    check("bp_first", s, exp_a);
    repeat (10) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_stable", st_out, exp_a);
      check("bp_in_ready", in_ready, 1'b0);
    end
    @(posedge clk); #1;
    st_in = b; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_fire", in_ready, 1'b1);
    check("bp_fire_data", st_out, exp_a);
    @(posedge clk); #1;
    t_acc = cyc;
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("bp_reload_busy", busy, 1'b1);
    check("bp_reload_ov", out_valid, 1'b0);
    recv(s, t_ov, 1'b1);
    check("bp_reload_latency", t_ov - t_acc, NCYC);
    check("bp_reload_data", s, model(b));

    // Reset while cnt==7.
    send(rand_state(), t_acc);
    repeat (7) @(posedge clk);
    #1;
    check("mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_out_valid", out_valid, 1'b0);
    check("mid_busy_clr", busy, 1'b0);
    check("mid_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    a = rand_state();
    send(a, t_acc);
    recv(s, t_ov, 1'b1);
    check("mid_fresh_latency", t_ov - t_acc, NCYC);
    check("mid_fresh_data", s, model(a));

    // Random regression with valid/ready gaps.
    begin
      logic [319:0] q[$];
      int unsigned  got;
      bit           abort;
      got = 0;
      abort = 1'b0;
      fork
        begin
          for (int k = 0; k < 1000 && !abort; k++) begin
            int n;
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            st_in = rand_state();
            in_valid = 1'b1;
            n = 0;
            forever begin
              @(negedge clk);
              if (in_ready) begin
                q.push_back(st_in);
                @(posedge clk); #1;
                break;
              end
              n++;
              if (n > 300) begin
                check("rnd_accept_timeout", in_ready, 1'b1);
                abort = 1'b1;
                break;
              end
            end
            in_valid = 1'b0;
          end
        end
        begin
          int unsigned n;
          n = 0;
          while (got < 1000 && n < 60000 && !abort) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (out_valid && out_ready) begin
              if (q.size() == 0) check("rnd_extra_output", 1'b1, 1'b0);
              else check("rnd_data", st_out, model(q.pop_front()));
              got++;
            end
            n++;
          end
          if (got != 1000) check("rnd_count", got, 1000);
        end
      join
      @(posedge clk); #1;
      out_ready = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("rnd_leftover", q.size(), 0);
      check("rnd_no_dup", got, 1000);
      @(negedge clk);
      check("rnd_idle_out_valid", out_valid, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
